spi_neopix_array: RTL and testbench
===================================

SPI_NEOPIX_ARRAY -- requirements
Module: spi_neopix_array

Interface
REQ-001 Parameter NUM_CHANNELS, default 2, number of independent pixel strips; legal range 1..8.
REQ-002 Parameter NUM_LEDS, default 256, pixels per strip, passed unchanged to every spi_to_neopix instance.
REQ-003 Parameter SYSTEM_CLOCK, default 50000000, clk_i frequency in Hz, passed to every instance.
REQ-004 Parameter MIN_DURATION, default SYSTEM_CLOCK/10-1, activity-LED hold time in cycles.
REQ-005 Parameter INIT_CYCLES, default 7, internal power-on/reset hold length in cycles; legal range 1..255.
REQ-006 clk_i  input  1  system clock; all state on its rising edge.
REQ-007 reset_i  input  1  reset, synchronous, active-high.
REQ-008 sck_i  input  1  shared SPI clock, asynchronous to clk_i.
REQ-009 mosi_i  input  1  shared SPI data in.
REQ-010 miso_o  output  1  shared SPI data out.
REQ-011 ssel_i  input  NUM_CHANNELS  per-channel SPI select, active-low.
REQ-012 do_o  output  NUM_CHANNELS  per-channel pixel bitstream.
REQ-013 ws_bsy_o  output  NUM_CHANNELS  per-channel bitstream-busy, direct from instance.
REQ-014 spi_led_o  output  NUM_CHANNELS  stretched SPI-activity indicator.
REQ-015 ws_led_o  output  NUM_CHANNELS  stretched bitstream-activity indicator.
REQ-016 collision_o  output  1  sticky flag: two or more selects asserted together.
REQ-017 collision_cnt_o  output  8  saturating count of collision events.
REQ-018 init_done_o  output  1  high once the internal reset hold has expired.

Function
REQ-019 Internal reset rst_int SHALL equal reset_i OR (init_cnt != 0); init_cnt is an 8-bit counter with power-up value INIT_CYCLES, decremented every cycle while nonzero and reset_i low.
REQ-020 reset_i high SHALL reload init_cnt with INIT_CYCLES, so rst_int stays high for INIT_CYCLES cycles after reset_i falls.
REQ-021 init_done_o SHALL equal (init_cnt == 0) AND NOT reset_i.
REQ-022 One spi_to_neopix instance per channel k SHALL receive clk_i, rst_int, sck_i, mosi_i and raw ssel_i[k], drive do_o[k] and ws_bsy_o[k].
REQ-023 miso_o SHALL be combinational: miso of channel k when exactly one ssel_i bit (k) is low; 0 when none or more than one are low.
REQ-024 Each ssel_i bit SHALL pass through a two-flop synchronizer (reset value 1) before use in the stretcher and collision logic; the raw bit is used only by the instance and the MISO mux.
REQ-025 Each stretcher (2*NUM_CHANNELS total; inputs: inverted synchronized ssel, ws_bsy_o) SHALL hold a counter of width clog2(MIN_DURATION+1): input high loads MIN_DURATION; otherwise nonzero counter decrements by 1.
REQ-026 Stretcher output SHALL be (input high) OR (counter != 0), so a pulse of P cycles yields an output of P+MIN_DURATION cycles; re-assertion during hold reloads the counter, no gap.
REQ-027 Collision condition SHALL be "two or more synchronized selects low"; it is registered as coll_q.
REQ-028 collision_o SHALL be set on any cycle with coll_q high and cleared only by rst_int.
REQ-029 collision_cnt_o SHALL increment by 1 on each rising edge of coll_q (coll_q high, previous value low) and saturate at 255.
REQ-030 NUM_CHANNELS = 1 SHALL give collision_o and collision_cnt_o constant 0 and miso_o = instance miso when ssel_i[0] low, else 0.

Reset
REQ-031 While rst_int high: spi_led_o = 0, ws_led_o = 0, stretcher counters = 0, synchronizers = all ones, coll_q = 0, collision_o = 0, collision_cnt_o = 0; instances held in reset.
REQ-032 reset_i asserted mid-transfer or mid-hold SHALL clear all indicators on the next clock edge with no residual stretch.

Verification
REQ-033 Power-up, reset_i low -> init_done_o low for exactly 7 cycles, then high; all LEDs and collision_o 0 throughout.
REQ-034 MIN_DURATION=20, ssel_i[1] low for 10 cycles -> spi_led_o[1] high for 30 cycles beginning 3 cycles after the select falls (2 synchronizer stages plus registered counter); spi_led_o[0] stays 0.
REQ-035 NUM_CHANNELS=4, ssel_i=4'b1011 -> miso_o follows channel 2; ssel_i=4'b1001 -> miso_o = 0.
REQ-036 ssel_i[0] and ssel_i[1] low together three separate times -> collision_o = 1, collision_cnt_o = 3; 300 events -> collision_cnt_o = 255.
REQ-037 reset_i pulsed during a stretch hold and with collision_o set -> all LEDs, collision_o and collision_cnt_o 0 next cycle; init_done_o low 7 cycles after reset_i falls.
REQ-038 Full 256-pixel frame sent on channel 0 -> do_o[0] emits the frame, ws_led_o[0] high for busy duration plus MIN_DURATION, do_o[1] idle.

Source files
------------

// File: rtl/spi_neopix_array.sv
// Multi-strip SPI-to-NeoPixel bridge: per-channel SPI slaves sharing SCK/MOSI/MISO,
// each buffering a frame and replaying it as a WS281x bitstream, plus activity LEDs and collision monitor.

module spi_to_neopix #(
    parameter int unsigned NUM_LEDS     = 256,
    parameter int unsigned SYSTEM_CLOCK = 50000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sck_i,
    input  logic mosi_i,
    output logic miso_o,
    input  logic ssel_i,
    output logic do_o,
    output logic ws_bsy_o
);
    localparam int unsigned BYTES   = NUM_LEDS * 3;
    localparam int unsigned IW      = $clog2(BYTES);
    localparam int unsigned AW      = $clog2(BYTES + 1);
    localparam int unsigned BIT_CYC = (SYSTEM_CLOCK / 800000 > 3) ? SYSTEM_CLOCK / 800000 : 3;
    localparam int unsigned T0H     = BIT_CYC / 3;
    localparam int unsigned T1H     = (2 * BIT_CYC) / 3;
    localparam int unsigned RST_CYC = (SYSTEM_CLOCK / 20000 > BIT_CYC) ? SYSTEM_CLOCK / 20000 : BIT_CYC;
    localparam int unsigned TW      = $clog2(RST_CYC + 1);

    typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_BIT, TX_LATCH} tx_state_e;

    logic [2:0]    sck_q;
    logic [1:0]    mosi_q;
    logic [2:0]    ssel_q;
    logic [7:0]    sr_q;
    logic [2:0]    bit_cnt_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] len_q;
    logic          start_q;
    logic [7:0]    mem [BYTES];

    tx_state_e     state_q, state_n;
    logic [AW-1:0] rd_ptr_q, rd_ptr_n;
    logic [7:0]    byte_q, byte_n;
    logic [2:0]    bit_idx_q, bit_idx_n;
    logic [TW-1:0] tim_q, tim_n, hi_len;
    logic          do_q, do_n, bsy_q, bsy_n;

    logic sck_rise, frame_end, byte_done;
    logic [7:0] rx_byte;

    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign frame_end = ssel_q[1] & ~ssel_q[2];
    assign rx_byte   = {sr_q[6:0], mosi_q[1]};
    assign byte_done = ~ssel_q[1] & sck_rise & (bit_cnt_q == 3'd7) & (wr_ptr_q != AW'(BYTES));
    assign miso_o    = sr_q[7];
    assign do_o      = do_q;
    assign ws_bsy_o  = bsy_q;

    // SPI mode 0 receiver; MISO echoes the byte shifted in one byte earlier
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sck_q     <= 3'b000;
            mosi_q    <= 2'b00;
            ssel_q    <= 3'b111;
            sr_q      <= 8'h00;
            bit_cnt_q <= 3'd0;
            wr_ptr_q  <= '0;
            len_q     <= '0;
            start_q   <= 1'b0;
        end else begin
            sck_q   <= {sck_q[1:0], sck_i};
            mosi_q  <= {mosi_q[0], mosi_i};
            ssel_q  <= {ssel_q[1:0], ssel_i};
            start_q <= 1'b0;
            if (!ssel_q[1]) begin
                if (sck_rise) begin
                    sr_q      <= rx_byte;
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                if (byte_done) wr_ptr_q <= wr_ptr_q + AW'(1);
            end else begin
                bit_cnt_q <= 3'd0;
            end
            // A frame arriving while the strip is still being refreshed is dropped
            if (frame_end) begin
                wr_ptr_q <= '0;
                if (wr_ptr_q != '0 && state_q == TX_IDLE) begin
                    len_q   <= wr_ptr_q;
                    start_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && byte_done) mem[wr_ptr_q[IW-1:0]] <= rx_byte;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= TX_IDLE;
            rd_ptr_q  <= '0;
            byte_q    <= 8'h00;
            bit_idx_q <= 3'd0;
            tim_q     <= '0;
            do_q      <= 1'b0;
            bsy_q     <= 1'b0;
        end else begin
            state_q   <= state_n;
            rd_ptr_q  <= rd_ptr_n;
            byte_q    <= byte_n;
            bit_idx_q <= bit_idx_n;
            tim_q     <= tim_n;
            do_q      <= do_n;
            bsy_q     <= bsy_n;
        end
    end

    // Bitstream generator: MSB first, each bit BIT_CYC long, then a latch gap
    always_comb begin
        state_n   = state_q;
        rd_ptr_n  = rd_ptr_q;
        byte_n    = byte_q;
        bit_idx_n = bit_idx_q;
        tim_n     = tim_q;
        do_n      = 1'b0;
        bsy_n     = (state_q != TX_IDLE);
        hi_len    = byte_q[bit_idx_q] ? TW'(T1H) : TW'(T0H);
        case (state_q)
            TX_IDLE: begin
                if (start_q) begin
                    rd_ptr_n = '0;
                    state_n  = TX_LOAD;
                end
            end
            TX_LOAD: begin
                byte_n    = mem[rd_ptr_q[IW-1:0]];
                bit_idx_n = 3'd7;
                tim_n     = '0;
                state_n   = TX_BIT;
            end
            TX_BIT: begin
                do_n = (tim_q < hi_len);
                if (tim_q == TW'(BIT_CYC - 1)) begin
                    tim_n = '0;
                    if (bit_idx_q == 3'd0) begin
                        if (rd_ptr_q == len_q - AW'(1)) begin
                            state_n = TX_LATCH;
                        end else begin
                            rd_ptr_n = rd_ptr_q + AW'(1);
                            state_n  = TX_LOAD;
                        end
                    end else begin
                        bit_idx_n = bit_idx_q - 3'd1;
                    end
                end else begin
                    tim_n = tim_q + TW'(1);
                end
            end
            TX_LATCH: begin
                if (tim_q == TW'(RST_CYC - 1)) state_n = TX_IDLE;
                else tim_n = tim_q + TW'(1);
            end
            default: state_n = TX_IDLE;
        endcase
    end
endmodule

module spi_neopix_array #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned NUM_LEDS     = 256,
    parameter int unsigned SYSTEM_CLOCK = 50000000,
    parameter int unsigned MIN_DURATION = SYSTEM_CLOCK / 10 - 1,
    parameter int unsigned INIT_CYCLES  = 7
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    sck_i,
    input  logic                    mosi_i,
    output logic                    miso_o,
    input  logic [NUM_CHANNELS-1:0] ssel_i,
    output logic [NUM_CHANNELS-1:0] do_o,
    output logic [NUM_CHANNELS-1:0] ws_bsy_o,
    output logic [NUM_CHANNELS-1:0] spi_led_o,
    output logic [NUM_CHANNELS-1:0] ws_led_o,
    output logic                    collision_o,
    output logic [7:0]              collision_cnt_o,
    output logic                    init_done_o
);
    localparam int unsigned NC = NUM_CHANNELS;
    localparam int unsigned NS = 2 * NC;
    localparam int unsigned CW = (MIN_DURATION > 0) ? $clog2(MIN_DURATION + 1) : 1;

    logic [7:0]    init_cnt_q = 8'(INIT_CYCLES);
    logic          rst_int;
    logic [NC-1:0] miso_ch, sel_c;
    logic [NC-1:0] ssel_s1_q, ssel_s2_q;
    logic [NS-1:0] str_in, led_q;
    logic [CW-1:0] str_cnt_q [NS];

    // Power-on hold: rst_int stays high until init_cnt drains
    always_ff @(posedge clk_i) begin
        if (reset_i) init_cnt_q <= 8'(INIT_CYCLES);
        else if (init_cnt_q != 8'd0) init_cnt_q <= init_cnt_q - 8'd1;
    end

    assign rst_int     = reset_i | (init_cnt_q != 8'd0);
    assign init_done_o = (init_cnt_q == 8'd0) & ~reset_i;

    for (genvar k = 0; k < NC; k++) begin : g_ch
        spi_to_neopix #(
            .NUM_LEDS    (NUM_LEDS),
            .SYSTEM_CLOCK(SYSTEM_CLOCK)
        ) u_pix (
            .clk_i   (clk_i),
            .reset_i (rst_int),
            .sck_i   (sck_i),
            .mosi_i  (mosi_i),
            .miso_o  (miso_ch[k]),
            .ssel_i  (ssel_i[k]),
            .do_o    (do_o[k]),
            .ws_bsy_o(ws_bsy_o[k])
        );
    end

    // Shared MISO only driven when exactly one slave is addressed
    assign sel_c  = ~ssel_i;
    assign miso_o = ($countones(sel_c) == 1) ? |(miso_ch & sel_c) : 1'b0;

    always_ff @(posedge clk_i) begin
        if (rst_int) begin
            ssel_s1_q <= '1;
            ssel_s2_q <= '1;
        end else begin
            ssel_s1_q <= ssel_i;
            ssel_s2_q <= ssel_s1_q;
        end
    end

    assign str_in    = {ws_bsy_o, ~ssel_s2_q};
    assign spi_led_o = led_q[NC-1:0];
    assign ws_led_o  = led_q[NS-1:NC];

    // Pulse stretchers so short activity stays visible for MIN_DURATION cycles
    always_ff @(posedge clk_i) begin
        if (rst_int) begin
            for (int i = 0; i < NS; i++) str_cnt_q[i] <= '0;
            led_q <= '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (str_in[i]) str_cnt_q[i] <= CW'(MIN_DURATION);
                else if (str_cnt_q[i] != '0) str_cnt_q[i] <= str_cnt_q[i] - CW'(1);
                led_q[i] <= str_in[i] | (str_cnt_q[i] != '0);
            end
        end
    end

    if (NC > 1) begin : g_coll
        logic       coll_q, coll_prev_q, collision_q;
        logic [7:0] coll_cnt_q;

        always_ff @(posedge clk_i) begin
            if (rst_int) begin
                coll_q      <= 1'b0;
                coll_prev_q <= 1'b0;
                collision_q <= 1'b0;
                coll_cnt_q  <= 8'd0;
            end else begin
                coll_q      <= ($countones(~ssel_s2_q) >= 2);
                coll_prev_q <= coll_q;
                collision_q <= collision_q | coll_q;
                if (coll_q && !coll_prev_q && coll_cnt_q != 8'hFF) coll_cnt_q <= coll_cnt_q + 8'd1;
            end
        end

        assign collision_o     = collision_q;
        assign collision_cnt_o = coll_cnt_q;
    end else begin : g_no_coll
        assign collision_o     = 1'b0;
        assign collision_cnt_o = 8'd0;
    end
endmodule

// File: tb/tb_spi_neopix_array.sv
// Directed bench for spi_neopix_array: init hold, LED stretch, MISO mux, collisions, reset, full frame.

module tb_spi_neopix_array;
    localparam int unsigned NC   = 4;
    localparam int unsigned LEDS = 256;
    localparam int unsigned SYS  = 4000000;
    localparam int unsigned MIN  = 20;
    localparam int unsigned INIT = 7;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          sck = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic [NC-1:0] ssel = '1;
    logic [NC-1:0] do_w, bsy, spi_led, ws_led;
    logic          coll;
    logic [7:0]    coll_cnt;
    logic          init_done;

    int total = 0;
    int bad   = 0;
    logic   bit_q[$];
    logic [7:0] byte_q[$];

    always #5 clk = ~clk;

    spi_neopix_array #(
        .NUM_CHANNELS(NC),
        .NUM_LEDS    (LEDS),
        .SYSTEM_CLOCK(SYS),
        .MIN_DURATION(MIN),
        .INIT_CYCLES (INIT)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .sck_i          (sck),
        .mosi_i         (mosi),
        .miso_o         (miso),
        .ssel_i         (ssel),
        .do_o           (do_w),
        .ws_bsy_o       (bsy),
        .spi_led_o      (spi_led),
        .ws_led_o       (ws_led),
        .collision_o    (coll),
        .collision_cnt_o(coll_cnt),
        .init_done_o    (init_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI mode-0 byte; with chk set, MISO is compared against the scoreboard before each rising SCK
    task automatic spi_xfer(input logic [7:0] d, input int h, input bit chk);
        logic exp_bit;
        for (int b = 7; b >= 0; b--) begin
            mosi = d[b];
            tick(h);
            if (chk) begin
                exp_bit = bit_q.pop_front();
                check("miso_bit", 32'(miso), 32'(exp_bit));
                bit_q.push_back(d[b]);
            end
            sck = 1'b1;
            tick(h);
            sck = 1'b0;
        end
    endtask

    task automatic coll_event(input int lo, input int hi);
        ssel[1:0] = 2'b00;
        tick(lo);
        ssel[1:0] = 2'b11;
        tick(hi);
    endtask

    initial begin
        int   n, first, hi, l0, noisy;
        int   bsy_cyc, led_cyc, nbytes, nbits, pulse, do1_seen;
        bit   seen_bsy, done;
        logic [7:0] cur, d, exp_byte;
        logic bit_v;

        #1;
        check("init_low_t0", 32'(init_done), 0);
        n = 0;
        noisy = 0;
        while (!init_done && n < 50) begin
            tick();
            n++;
            if ((spi_led | ws_led) != '0 || coll) noisy = 1;
        end
        check("init_cycles", n, INIT);
        check("init_done", 32'(init_done), 1);
        check("quiet_during_init", noisy, 0);

        // 10-cycle select on channel 1
        ssel[1] = 1'b0;
        first = 0; hi = 0; l0 = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (spi_led[1]) begin
                if (first == 0) first = i;
                hi++;
            end
            if (spi_led[0]) l0 = 1;
            if (i == 10) ssel[1] = 1'b1;
        end
        check("spi_led_start", first, 3);
        check("spi_led_len", hi, 10 + MIN);
        check("spi_led0_quiet", l0, 0);

        check("coll_clear", 32'(coll), 0);
        coll_event(4, 4);
        check("coll_set_1", 32'(coll), 1);
        check("coll_cnt_1", 32'(coll_cnt), 1);
        coll_event(4, 4);
        coll_event(4, 4);
        check("coll_cnt_3", 32'(coll_cnt), 3);
        check("coll_set_3", 32'(coll), 1);

        // MISO through channel 2: reset shift register, then each byte echoes one byte later
        ssel = 4'b1011;
        for (int i = 0; i < 8; i++) bit_q.push_back(1'b0);
        tick(4);
        spi_xfer(8'hA5, 4, 1);
        spi_xfer(8'hC3, 4, 1);
        tick(4);
        bit_v = bit_q.pop_front();
        check("miso_static_c2", 32'(miso), 32'(bit_v));
        bit_q.delete();
        ssel = 4'b1001;
        #1;
        check("miso_two_sel", 32'(miso), 0);
        ssel = 4'b1111;
        #1;
        check("miso_no_sel", 32'(miso), 0);
        tick(4);

        repeat (300) coll_event(3, 3);
        tick(4);
        check("coll_cnt_sat", 32'(coll_cnt), 255);
        check("coll_set_sat", 32'(coll), 1);

        // reset in the middle of a stretch hold
        ssel[1] = 1'b0;
        tick(5);
        ssel[1] = 1'b1;
        tick(6);
        check("hold_active", 32'(spi_led[1]), 1);
        reset_i = 1'b1;
        tick();
        check("rst_spi_led", 32'(spi_led), 0);
        check("rst_ws_led", 32'(ws_led), 0);
        check("rst_coll", 32'(coll), 0);
        check("rst_coll_cnt", 32'(coll_cnt), 0);
        check("rst_init_done", 32'(init_done), 0);
        reset_i = 1'b0;
        n = 0;
        while (!init_done && n < 50) begin
            tick();
            n++;
        end
        check("reinit_cycles", n, INIT);
        tick(30);
        check("no_residual_led", 32'(spi_led | ws_led), 0);

        // Full frame on channel 0
        ssel = 4'b1110;
        tick(4);
        for (int i = 0; i < LEDS * 3; i++) begin
            d = 8'($urandom);
            byte_q.push_back(d);
            spi_xfer(d, 2, 0);
        end
        tick(4);
        ssel = 4'b1111;

        bsy_cyc = 0; led_cyc = 0; nbytes = 0; nbits = 0; pulse = 0; do1_seen = 0;
        seen_bsy = 0; done = 0; cur = 8'h00;
        for (int c = 0; c < 60000 && !done; c++) begin
            tick();
            if (bsy[0]) begin
                bsy_cyc++;
                seen_bsy = 1;
            end
            if (ws_led[0]) led_cyc++;
            if (do_w[1]) do1_seen = 1;
            if (do_w[0]) begin
                pulse++;
            end else if (pulse > 0) begin
                // high time above 0.6 us decodes as a one
                bit_v = (longint'(pulse) * 10000000 > 6 * longint'(SYS));
                cur = {cur[6:0], bit_v};
                pulse = 0;
                nbits++;
                if (nbits == 8) begin
                    nbits = 0;
                    nbytes++;
                    if (byte_q.size() > 0) begin
                        exp_byte = byte_q.pop_front();
                        check("frame_byte", 32'(cur), 32'(exp_byte));
                    end
                end
            end
            if (seen_bsy && !bsy[0] && !ws_led[0]) done = 1;
        end
        check("frame_finished", 32'(done), 1);
        check("frame_byte_count", nbytes, LEDS * 3);
        check("frame_bytes_left", byte_q.size(), 0);
        check("ws_led_len", led_cyc, bsy_cyc + MIN);
        check("do1_idle", do1_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
